// File: rtl/cmp_check_pkg.sv
// Shared types and default sizing for the comparator result checker.
package cmp_check_pkg;

  localparam int unsigned DefWidth      = 4;
  localparam int unsigned DefNumSamples = 18;
  localparam int unsigned DefCntW       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cmp_result_checker_if.sv
// Sample stream from the comparator under test into the checker.
interface cmp_result_checker_if #(
  parameter int unsigned WIDTH = cmp_check_pkg::DefWidth
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             e_obs;
  logic             g_obs;
  logic             l_obs;

  modport master (
    output in_valid, a, b, e_obs, g_obs, l_obs,
    input  in_ready
  );

  modport slave (
    input  in_valid, a, b, e_obs, g_obs, l_obs,
    output in_ready
  );
endinterface

// File: rtl/cmp_expect.sv
// Reference comparator: one-hot equal/greater/less flags for unsigned operands.
module cmp_expect #(
  parameter int unsigned WIDTH = cmp_check_pkg::DefWidth
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             e,
  output logic             g,
  output logic             l
);
  assign e = (a == b);
  assign g = (a > b);
  assign l = (a < b);
endmodule

// File: rtl/cmp_result_checker.sv
// Checks a run of comparator samples against cmp_expect and accumulates
// saturating pass/fail statistics.
module cmp_result_checker
  import cmp_check_pkg::*;
#(
  parameter int unsigned WIDTH       = DefWidth,
  parameter int unsigned NUM_SAMPLES = DefNumSamples,
  parameter int unsigned CNT_W       = DefCntW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  cmp_result_checker_if.slave  smp,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     err_count,
  output logic [CNT_W-1:0]     eq_count,
  output logic [CNT_W-1:0]     gt_count,
  output logic [CNT_W-1:0]     lt_count,
  output logic [CNT_W-1:0]     first_err_idx,
  output logic                 first_err_valid
);

  // The run index must reach NUM_SAMPLES-1 even when that exceeds the counter range.
  localparam int unsigned IdxW =
      ($clog2(NUM_SAMPLES) > CNT_W) ? $clog2(NUM_SAMPLES) : CNT_W;
  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(NUM_SAMPLES - 1);

  state_e           state_q;
  logic [IdxW-1:0]  idx_q;
  logic [CNT_W-1:0] err_q, eq_q, gt_q, lt_q, first_idx_q;
  logic             first_valid_q;

  logic             exp_e, exp_g, exp_l;
  logic             hs, mismatch;
  logic [CNT_W-1:0] idx_sat;

  cmp_expect #(
    .WIDTH (WIDTH)
  ) u_expect (
    .a (smp.a),
    .b (smp.b),
    .e (exp_e),
    .g (exp_g),
    .l (exp_l)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CntMax) ? v : v + CNT_W'(1);
  endfunction

  assign smp.in_ready = (state_q == RUN);
  assign hs           = smp.in_valid && smp.in_ready;
  assign mismatch     = {smp.e_obs, smp.g_obs, smp.l_obs} != {exp_e, exp_g, exp_l};

  always_comb begin
    idx_sat = idx_q[CNT_W-1:0];
    if (idx_q > IdxW'(CntMax)) idx_sat = CntMax;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      err_q         <= '0;
      eq_q          <= '0;
      gt_q          <= '0;
      lt_q          <= '0;
      first_idx_q   <= '0;
      first_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q       <= RUN;
            idx_q         <= '0;
            err_q         <= '0;
            eq_q          <= '0;
            gt_q          <= '0;
            lt_q          <= '0;
            first_idx_q   <= '0;
            first_valid_q <= 1'b0;
          end
        end
        RUN: begin
          if (hs) begin
            if (exp_e) eq_q <= sat_inc(eq_q);
            if (exp_g) gt_q <= sat_inc(gt_q);
            if (exp_l) lt_q <= sat_inc(lt_q);
            if (mismatch) begin
              err_q <= sat_inc(err_q);
              if (!first_valid_q) begin
                first_idx_q   <= idx_sat;
                first_valid_q <= 1'b1;
              end
            end
            if (idx_q == LastIdx) state_q <= DONE;
            else                  idx_q   <= idx_q + IdxW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy            = (state_q == RUN);
  assign done            = (state_q == DONE);
  assign pass            = done && (err_q == '0);
  assign err_count       = err_q;
  assign eq_count        = eq_q;
  assign gt_count        = gt_q;
  assign lt_count        = lt_q;
  assign first_err_idx   = first_idx_q;
  assign first_err_valid = first_valid_q;

endmodule

// File: tb/tb_cmp_result_checker.sv
// Scoreboard bench for cmp_result_checker: default 18-sample instance plus a
// 300-sample instance for counter saturation.
module tb_cmp_result_checker;
  import cmp_check_pkg::*;

  typedef struct {
    logic e;
    logic g;
    logic l;
    logic mis;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic big_start = 1'b0;
  always #5 clk = ~clk;

  cmp_result_checker_if #(.WIDTH(4)) smp_if ();
  cmp_result_checker_if #(.WIDTH(4)) big_if ();

  logic       busy, done, pass, fev;
  logic [7:0] err_count, eq_count, gt_count, lt_count, fei;
  logic       b_busy, b_done, b_pass, b_fev;
  logic [7:0] b_err, b_eq, b_gt, b_lt, b_fei;

  cmp_result_checker #(.WIDTH(4), .NUM_SAMPLES(18), .CNT_W(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .smp             (smp_if),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .eq_count        (eq_count),
    .gt_count        (gt_count),
    .lt_count        (lt_count),
    .first_err_idx   (fei),
    .first_err_valid (fev)
  );

  cmp_result_checker #(.WIDTH(4), .NUM_SAMPLES(300), .CNT_W(8)) dut_big (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (big_start),
    .smp             (big_if),
    .busy            (b_busy),
    .done            (b_done),
    .pass            (b_pass),
    .err_count       (b_err),
    .eq_count        (b_eq),
    .gt_count        (b_gt),
    .lt_count        (b_lt),
    .first_err_idx   (b_fei),
    .first_err_valid (b_fev)
  );

  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb[$];
  int   m_err, m_eq, m_gt, m_lt, m_idx, m_fei;
  logic m_fev;

  function automatic logic [2:0] good(input logic [3:0] a, input logic [3:0] b);
    return {a == b, a > b, a < b};
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_clear();
    m_err = 0; m_eq = 0; m_gt = 0; m_lt = 0; m_idx = 0; m_fei = 0; m_fev = 1'b0;
    sb.delete();
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] obs);
    exp_t x;
    @(negedge clk);
    n_total++;
    if (smp_if.in_ready !== 1'b1)
      $display("FAIL in_ready before sample %0d: got %b want 1", m_idx, smp_if.in_ready);
    else n_pass++;
    smp_if.in_valid = 1'b1;
    smp_if.a = a;
    smp_if.b = b;
    {smp_if.e_obs, smp_if.g_obs, smp_if.l_obs} = obs;
    x.e = (a == b); x.g = (a > b); x.l = (a < b);
    x.mis = (obs !== {x.e, x.g, x.l});
    sb.push_back(x);
    @(posedge clk);
    #1;
    smp_if.in_valid = 1'b0;
    x = sb.pop_front();
    if (x.e) m_eq = sat(m_eq + 1);
    if (x.g) m_gt = sat(m_gt + 1);
    if (x.l) m_lt = sat(m_lt + 1);
    if (x.mis) begin
      m_err = sat(m_err + 1);
      if (!m_fev) begin m_fei = m_idx; m_fev = 1'b1; end
    end
    m_idx++;
    n_total++;
    if ({err_count, eq_count, gt_count, lt_count} !==
        {8'(m_err), 8'(m_eq), 8'(m_gt), 8'(m_lt)})
      $display("FAIL counts after sample %0d: got err/eq/gt/lt %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               m_idx - 1, err_count, eq_count, gt_count, lt_count, m_err, m_eq, m_gt, m_lt);
    else n_pass++;
    n_total++;
    if ({fev, fei} !== {m_fev, 8'(m_fei)})
      $display("FAIL first_err after sample %0d: got %b/%0d want %b/%0d",
               m_idx - 1, fev, fei, m_fev, m_fei);
    else n_pass++;
  endtask

  task automatic send_rand_good(input int n);
    logic [3:0] ra, rb;
    for (int i = 0; i < n; i++) begin
      ra = 4'($urandom_range(15, 0));
      rb = 4'($urandom_range(15, 0));
      send(ra, rb, good(ra, rb));
    end
  endtask

  task automatic test_reset();
    #1;
    n_total++;
    if ({smp_if.in_ready, busy, done, pass, fev} !== 5'b0)
      $display("FAIL reset flags: got %b want 00000", {smp_if.in_ready, busy, done, pass, fev});
    else n_pass++;
    n_total++;
    if ({err_count, eq_count, gt_count, lt_count, fei} !== 40'h0)
      $display("FAIL reset counts: got %h want 0", {err_count, eq_count, gt_count, lt_count, fei});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_pass_run();
    do_start();
    send(4'd5, 4'd5, 3'b100);
    send(4'd9, 4'd3, 3'b010);
    send(4'd2, 4'd14, 3'b001);
    send_rand_good(15);
    n_total++;
    if ({done, busy, pass, smp_if.in_ready} !== 4'b1010)
      $display("FAIL pass_run status: got done/busy/pass/rdy %b want 1010",
               {done, busy, pass, smp_if.in_ready});
    else n_pass++;
    n_total++;
    if (int'(eq_count) + int'(gt_count) + int'(lt_count) !== 18)
      $display("FAIL pass_run class sum: got %0d want 18",
               int'(eq_count) + int'(gt_count) + int'(lt_count));
    else n_pass++;
  endtask

  task automatic test_first_err();
    do_start();
    send_rand_good(3);
    send(4'd4, 4'd4, 3'b010);
    send_rand_good(14);
    n_total++;
    if ({err_count, fei, fev, pass, done} !== {8'd1, 8'd3, 3'b101})
      $display("FAIL first_err result: got err=%0d idx=%0d v=%b pass=%b done=%b want 1,3,1,0,1",
               err_count, fei, fev, pass, done);
    else n_pass++;
  endtask

  task automatic test_bad_onehot();
    do_start();
    send(4'd0, 4'd15, 3'b000);
    send(4'd0, 4'd15, 3'b111);
    n_total++;
    if ({err_count, lt_count} !== {8'd2, 8'd2})
      $display("FAIL bad_onehot: got err=%0d lt=%0d want 2,2", err_count, lt_count);
    else n_pass++;
    send_rand_good(16);
    n_total++;
    if ({done, pass, fei} !== {2'b10, 8'd0})
      $display("FAIL bad_onehot end: got done=%b pass=%b idx=%0d want 1,0,0", done, pass, fei);
    else n_pass++;
  endtask

  task automatic test_stall();
    // in_valid while DONE must not be accepted
    @(negedge clk);
    smp_if.in_valid = 1'b1;
    {smp_if.a, smp_if.b, smp_if.e_obs, smp_if.g_obs, smp_if.l_obs} = {4'd1, 4'd2, 3'b000};
    @(negedge clk);
    smp_if.in_valid = 1'b0;
    n_total++;
    if ({done, err_count, eq_count, gt_count, lt_count} !==
        {1'b1, 8'(m_err), 8'(m_eq), 8'(m_gt), 8'(m_lt)})
      $display("FAIL done_hold: got done=%b err/eq/gt/lt %0d/%0d/%0d/%0d want 1 %0d/%0d/%0d/%0d",
               done, err_count, eq_count, gt_count, lt_count, m_err, m_eq, m_gt, m_lt);
    else n_pass++;
    do_start();
    send_rand_good(2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = (i == 2);
    end
    @(negedge clk);
    start = 1'b0;
    n_total++;
    if ({busy, err_count, eq_count, gt_count, lt_count} !==
        {1'b1, 8'(m_err), 8'(m_eq), 8'(m_gt), 8'(m_lt)})
      $display("FAIL stall: got busy=%b err/eq/gt/lt %0d/%0d/%0d/%0d want 1 %0d/%0d/%0d/%0d",
               busy, err_count, eq_count, gt_count, lt_count, m_err, m_eq, m_gt, m_lt);
    else n_pass++;
    send_rand_good(15);
    n_total++;
    if ({done, busy} !== 2'b01)
      $display("FAIL stall early done: got done/busy %b want 01", {done, busy});
    else n_pass++;
    send_rand_good(1);
    n_total++;
    if ({done, busy} !== 2'b10)
      $display("FAIL stall final done: got done/busy %b want 10", {done, busy});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_start();
    send_rand_good(4);
    send(4'd3, 4'd7, 3'b100);
    send_rand_good(4);
    send(4'd8, 4'd8, 3'b000);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy, done, pass, fev, smp_if.in_ready, err_count, eq_count, gt_count, lt_count, fei}
        !== 45'h0)
      $display("FAIL reset_mid async: got busy=%b done=%b err=%0d eq=%0d gt=%0d lt=%0d want all 0",
               busy, done, err_count, eq_count, gt_count, lt_count);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if ({busy, done, smp_if.in_ready} !== 3'b000)
      $display("FAIL reset_mid idle: got busy/done/rdy %b want 000", {busy, done, smp_if.in_ready});
    else n_pass++;
    do_start();
    send_rand_good(5);
    send(4'd12, 4'd1, 3'b001);
    send_rand_good(12);
    n_total++;
    if ({done, err_count, fei, fev} !== {1'b1, 8'd1, 8'd5, 1'b1})
      $display("FAIL reset_mid rerun: got done=%b err=%0d idx=%0d v=%b want 1,1,5,1",
               done, err_count, fei, fev);
    else n_pass++;
    n_total++;
    if (int'(eq_count) + int'(gt_count) + int'(lt_count) !== 18)
      $display("FAIL reset_mid class sum: got %0d want 18",
               int'(eq_count) + int'(gt_count) + int'(lt_count));
    else n_pass++;
  endtask

  task automatic test_saturation();
    logic [3:0] ra, rb;
    @(negedge clk);
    big_start = 1'b1;
    @(negedge clk);
    big_start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (i == 299) begin
        n_total++;
        if ({b_busy, b_done, b_gt} !== {2'b10, 8'd255})
          $display("FAIL sat before last: got busy=%b done=%b gt=%0d want 1,0,255",
                   b_busy, b_done, b_gt);
        else n_pass++;
      end
      ra = 4'($urandom_range(15, 1));
      rb = 4'($urandom_range(int'(ra) - 1, 0));
      big_if.in_valid = 1'b1;
      big_if.a = ra;
      big_if.b = rb;
      {big_if.e_obs, big_if.g_obs, big_if.l_obs} = 3'b010;
    end
    @(posedge clk);
    #1;
    big_if.in_valid = 1'b0;
    n_total++;
    if ({b_done, b_pass, b_gt, b_eq, b_lt, b_err} !== {2'b11, 8'd255, 24'h0})
      $display("FAIL saturation: got done=%b pass=%b gt=%0d eq=%0d lt=%0d err=%0d want 1,1,255,0,0,0",
               b_done, b_pass, b_gt, b_eq, b_lt, b_err);
    else n_pass++;
  endtask

  initial begin
    smp_if.in_valid = 1'b0;
    smp_if.a = '0;
    smp_if.b = '0;
    {smp_if.e_obs, smp_if.g_obs, smp_if.l_obs} = 3'b000;
    big_if.in_valid = 1'b0;
    big_if.a = '0;
    big_if.b = '0;
    {big_if.e_obs, big_if.g_obs, big_if.l_obs} = 3'b000;
    model_clear();
    test_reset();
    test_pass_run();
    test_first_err();
    test_bad_onehot();
    test_stall();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cmp_result_checker.md
CMP_RESULT_CHECKER -- requirements
Module: cmp_result_checker

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, 4, operand width in bits.
REQ-002 Parameter NUM_SAMPLES SHALL be: NUM_SAMPLES, 18, number of vectors checked per run.
REQ-003 Parameter CNT_W SHALL be: CNT_W, 8, width of all counters and indices.
REQ-004 Port clk SHALL be: clk, input, 1, the single rising-edge clock.
REQ-005 Port rst_n SHALL be: rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port start SHALL be: start, input, 1, one-cycle pulse that begins a run.
REQ-007 Port in_valid SHALL be: in_valid, input, 1, sample present on a/b/e_obs/g_obs/l_obs.
REQ-008 Port in_ready SHALL be: in_ready, output, 1, checker accepts a sample this cycle.
REQ-009 Ports a and b SHALL be: a, b, input, WIDTH, unsigned operands applied to the comparator under test.
REQ-010 Ports e_obs, g_obs and l_obs SHALL be: e_obs, g_obs, l_obs, input, 1 each, observed equal/greater/less flags.
REQ-011 Port busy SHALL be: busy, output, 1, high while in RUN.
REQ-012 Port done SHALL be: done, output, 1, high while in DONE.
REQ-013 Port pass SHALL be: pass, output, 1, high when done and err_count is 0.
REQ-014 Port err_count SHALL be: err_count, output, CNT_W, number of mismatching samples.
REQ-015 Ports eq_count, gt_count and lt_count SHALL be: eq_count, gt_count, lt_count, output, CNT_W each, counts of expected a==b, a>b and a<b.
REQ-016 Port first_err_idx SHALL be: first_err_idx, output, CNT_W, index (0-based) of the first mismatching sample.
REQ-017 Port first_err_valid SHALL be: first_err_valid, output, 1, first_err_idx holds a captured index.

Function
REQ-018 The checker SHALL be a three-state FSM: IDLE, RUN, DONE.
REQ-019 IDLE->RUN on start; DONE->RUN on start; both transitions SHALL clear all counters, sample index and first_err_valid in the same edge.
REQ-020 start in RUN SHALL be ignored.
REQ-021 in_ready SHALL equal (state==RUN), combinationally from the state register.
REQ-022 A handshake SHALL occur on any rising edge where in_valid && in_ready; in_valid without in_ready SHALL have no effect.
REQ-023 Expected flags SHALL be E=(a==b), G=(a>b), L=(a<b), unsigned, with exactly one high.
REQ-024 A sample SHALL mismatch when {e_obs,g_obs,l_obs} differs from the expected triple, including any non-one-hot observation (000, 011, 111, ...).
REQ-025 On a handshake, exactly one of eq/gt/lt_count SHALL increment (per the expected triple), and err_count SHALL increment on mismatch; all are updated at the same clock edge, i.e. visible one cycle after acceptance.
REQ-026 All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 On the first mismatch of a run, first_err_idx SHALL load the current sample index and first_err_valid SHALL set; later mismatches SHALL not change them.
REQ-028 On the handshake of sample NUM_SAMPLES-1, the FSM SHALL go RUN->DONE at that same edge; that sample SHALL still be counted.
REQ-029 In DONE all result outputs SHALL hold stable until the next start or reset.
REQ-030 pass SHALL be combinational: done && (err_count==0).

Reset
REQ-031 While rst_n is low, state SHALL be IDLE, and in_ready, busy, done, pass, first_err_valid SHALL be 0; all counters and first_err_idx SHALL be 0.
REQ-032 rst_n asserting mid-run SHALL abort the run immediately, with no partial sample counted; after release, the checker SHALL wait in IDLE for start.

Structure
REQ-033 Package cmp_check_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default WIDTH/NUM_SAMPLES/CNT_W constants.
REQ-034 The expected-flag model SHALL be a combinational sub-module cmp_expect (a, b -> E, G, L), instantiated once.

Verification
REQ-035 Reset then start, then 18 correct samples including (5,5),(9,3),(2,14) -> done after the 18th handshake, pass=1, err_count=0, eq+gt+lt=18.
REQ-036 Sample 3 observed 010 while a=4, b=4 -> err_count=1, first_err_idx=3, first_err_valid=1, pass=0.
REQ-037 Observed flags 000 and then 111 for a=0, b=15 -> both counted as errors; lt_count increments twice.
REQ-038 in_valid held low for 5 cycles in RUN, and start pulsed in RUN -> no counter change and no restart.
REQ-039 rst_n low after the 10th handshake -> all outputs 0 asynchronously; a new start followed by 18 samples -> the counts reflect only the new run.
REQ-040 NUM_SAMPLES=300 with CNT_W=8 and all a>b -> gt_count saturates at 255, and done is still asserted.
